// File: rtl/tx_axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tx_axis_frame_arbiter
//
// Purpose:
//   Shares the single AXI-Stream input of tx_mac between NUM_PORTS frame
//   sources. Arbitration is round-robin at frame granularity: once a port is
//   granted it owns the bus until its tlast beat is accepted, so frames never
//   interleave. One arbitration cycle (no transfers) separates frames.
//
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_port_enable      per-port arbitration enable (sampled only while idle)
//   s_axis_*           packed slave streams, port n occupies slice n
//   m_axis_*           master stream towards tx_mac
//   o_grant_id         port that owns, or last owned, the bus
//   o_busy             high while a frame is in progress
//   o_frame_done       one-cycle pulse when the tlast beat is accepted
// ---------------------------------------------------------------------------
module tx_axis_frame_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_PORTS-1:0]             i_port_enable,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    output logic [NUM_PORTS-1:0]             s_axis_trdy,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_trdy,
    output logic [ID_WIDTH-1:0]              o_grant_id,
    output logic                             o_busy,
    output logic                             o_frame_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] grant_q;
    logic [ID_WIDTH-1:0] last_grant_q;
    logic                busy_q;

    logic [ID_WIDTH-1:0] grant_d;
    logic                req_found;
    logic [NUM_PORTS-1:0] req;
    logic [ID_WIDTH:0]   cand;
    logic                xfer;
    logic                tlast_accept;

    assign req  = s_axis_tvalid & i_port_enable;
    assign xfer = (state_q == ST_XFER);

    // Round-robin search starting one past the last owner, with wrap-around.
    // The candidate is kept one bit wider so the wrap works for any
    // NUM_PORTS, not only powers of two.
    always_comb begin
        grant_d   = grant_q;
        req_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = {1'b0, last_grant_q} + (ID_WIDTH+1)'(i);
            if (cand >= (ID_WIDTH+1)'(NUM_PORTS)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_PORTS);
            end
            if (!req_found && req[cand[ID_WIDTH-1:0]]) begin
                grant_d   = cand[ID_WIDTH-1:0];
                req_found = 1'b1;
            end
        end
    end

    // Combinational datapath: the granted slice is forwarded with zero
    // latency while in XFER; everything is forced low while arbitrating.
    assign m_axis_tdata  = xfer ? s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_axis_tkeep  = xfer ? s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH] : '0;
    assign m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
    assign m_axis_tlast  = xfer & s_axis_tlast[grant_q];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_trdy
            assign s_axis_trdy[gi] = xfer && (grant_q == ID_WIDTH'(gi)) && m_axis_trdy;
        end
    endgenerate

    assign tlast_accept = m_axis_tvalid & m_axis_trdy & m_axis_tlast;
    assign o_frame_done = tlast_accept;
    assign o_grant_id   = grant_q;
    assign o_busy       = busy_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Enable is only looked at here; a mid-frame disable
                    // does not cut the frame short.
                    if (req_found) begin
                        grant_q <= grant_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tlast_accept) begin
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_axis_frame_arbiter.md
Name: tx_axis_frame_arbiter

Overview:
- Shares the single AXI-Stream input of tx_mac between NUM_PORTS independent frame sources.
- Sits directly upstream of tx_mac. Its master port connects to tx_mac s_axis_*.
- Arbitration is round-robin at frame granularity. Once a port is granted, it owns the bus until its tlast beat is accepted, so frames never interleave.
- Per-port enable mask lets software or the host quiesce individual sources.

Parameters:
- DATA_WIDTH, 32, beat width in bits; must equal tx_mac XGMII_DATA_WIDTH.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- NUM_PORTS, 4, number of requesters; legal range 2..8.
- ID_WIDTH, $clog2(NUM_PORTS), width of the grant index.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_port_enable  in  NUM_PORTS  per-port arbitration enable; bit n gates port n.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed slave data; port n occupies slice n.
- s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  packed slave keep.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_trdy  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  to tx_mac.
- m_axis_tkeep  out  KEEP_WIDTH  to tx_mac.
- m_axis_tvalid  out  1  to tx_mac.
- m_axis_tlast  out  1  to tx_mac.
- m_axis_trdy  in  1  from tx_mac.
- o_grant_id  out  ID_WIDTH  index of the port that owns, or last owned, the bus.
- o_busy  out  1  high while a frame is in progress.
- o_frame_done  out  1  single-cycle pulse on the cycle the tlast beat is accepted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs are 0: m_axis_*, s_axis_trdy, o_busy, o_frame_done, o_grant_id.
  - Last-grant pointer = NUM_PORTS-1, so port 0 has first priority after reset.
- FSM has two states, IDLE and XFER.
- IDLE:
  - req = s_axis_tvalid & i_port_enable.
  - If req != 0: select the first set bit searching from (last_grant+1) mod NUM_PORTS upward with wrap-around. Register it into grant and o_grant_id, set o_busy, and go to XFER on the next edge.
  - All s_axis_trdy and m_axis_tvalid stay 0 in IDLE, so no beat transfers in the arbitration cycle.
  - If req == 0: remain in IDLE.
- XFER (datapath is combinational; 0-cycle latency):
  - m_axis_tdata/tkeep/tlast/tvalid = slice [grant] of the slave inputs.
  - s_axis_trdy[grant] = m_axis_trdy; all other trdy bits = 0.
  - A beat transfers when m_axis_tvalid & m_axis_trdy.
  - tvalid gaps mid-frame are legal; the grant is held.
  - m_axis_trdy low (tx_mac backpressure) stalls the granted source; the grant is held.
- Frame end:
  - On an accepted beat with tlast=1: o_frame_done=1 for that cycle, last_grant<=grant, o_busy<=0, next state=IDLE.
- Throughput: minimum one idle bus cycle between consecutive frames (the arbitration bubble). tx_mac inter-packet gap absorbs it.
- Boundary conditions:
  - i_port_enable[grant] deasserting mid-frame is ignored until tlast. Enable is sampled only in IDLE.
  - A single requester is re-granted back-to-back: frame, 1 bubble, frame.
  - Wrap-around: last_grant=NUM_PORTS-1 searches from port 0.
  - One-beat frame (tvalid and tlast on the first XFER cycle): completes in one cycle and returns to IDLE.
  - Reset asserted mid-frame: immediately returns to the reset state. The partial frame is abandoned. The source must also be reset; no recovery logic.
  - Port deasserting tvalid during IDLE before being granted: not granted; the request is re-evaluated every IDLE cycle.
- o_grant_id holds its value in IDLE; it changes only on a new grant.
- Implementation must be synthesizable. No latches; the grant mux uses indexed part-selects.

Test Plan:
- Single port: port 0 sends a 16-beat frame, m_axis_trdy=1.
  - Expect: 1 idle cycle, then 16 beats passed unmodified on m_axis.
  - Expect: o_frame_done pulses once, o_grant_id=0, s_axis_trdy[3:1]=0 throughout.
- Round-robin: all 4 ports hold 3-beat frames continuously.
  - Expect grant order 0,1,2,3,0,1.
  - Expect exactly one bubble cycle between frames; no interleaved beats.
- Backpressure and gaps: port 2 sends an 8-beat frame while m_axis_trdy toggles 1,0,0,1 and port 2 inserts a 2-cycle tvalid gap at beat 4; port 1 requests mid-frame.
  - Expect: grant stays 2 until tlast; the data sequence is intact; port 1 is granted after the next IDLE cycle.
- Enable mask: i_port_enable=4'b1010, all ports requesting.
  - Expect: only ports 1 and 3 are granted, alternating.
  - Clearing bit 1 mid-frame of port 1: expect that frame still completes and port 1 is not granted again.
- Wrap and one-beat frames: last_grant=3, ports 0 and 3 each send 1-beat frames repeatedly.
  - Expect order 0,3,0,3, with a frame_done pulse every 2 cycles.
- Reset mid-frame: assert i_reset_n=0 at beat 5 of a port-1 frame.
  - Expect: all outputs are 0 asynchronously.
  - After release, with ports 0 and 1 requesting, expect port 0 to be granted first.
